crypto_feistel_slave: RTL



---
 rtl/crypto_pkg.sv | 49 ++++
 rtl/feistel_f.sv | 26 ++
 rtl/crypto_feistel_slave.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/crypto_pkg.sv
// -----------------------------------------------------------------------------
// crypto_pkg
//   Shared definitions for the crypto_feistel_slave accelerator: datapath
//   width, register offsets, CTRL/STAT bit positions, FSM state type, the
//   default ID constant and the round-key helper.
// -----------------------------------------------------------------------------
package crypto_pkg;

    // Width of one Feistel half, one key word and one bus word.
    localparam int W = 19;

    localparam logic [W-1:0] ID_DEFAULT = 19'h7C0DE;

    // Register offsets (addr[2:0]).
    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_KEY0   = 3'd1;
    localparam logic [2:0] A_KEY1   = 3'd2;
    localparam logic [2:0] A_DIN_L  = 3'd3;
    localparam logic [2:0] A_DIN_R  = 3'd4;
    localparam logic [2:0] A_DOUT_L = 3'd5;
    localparam logic [2:0] A_DOUT_R = 3'd6;
    localparam logic [2:0] A_ID     = 3'd7;

    // CTRL write bits.
    localparam int CTRL_START    = 0;
    localparam int CTRL_MODE     = 1;
    localparam int CTRL_DONE_CLR = 2;

    // STAT read bits.
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_MODE = 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Round key: even rounds use KEY0, odd rounds KEY1, each XORed with the
    // zero-extended round index.
    function automatic logic [W-1:0] round_key(
        input logic [W-1:0] key0,
        input logic [W-1:0] key1,
        input logic [2:0]   idx
    );
        return (idx[0] ? key1 : key0) ^ {{(W-3){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/feistel_f.sv
// -----------------------------------------------------------------------------
// feistel_f
//   Combinational Feistel round function F(x,k) = rotl(x,3) ^ (x + k) mod 2^W.
//   Ports:
//     x  in  W  data half
//     k  in  W  round key
//     f  out W  round function result
// -----------------------------------------------------------------------------
module feistel_f
    import crypto_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] k,
    output logic [W-1:0] f
);

    logic [W-1:0] rot;
    logic [W-1:0] sum;

    always_comb begin
        rot = {x[W-4:0], x[W-1:W-3]};
        sum = x + k;   // carry out of bit W-1 is discarded (mod 2^W)
        f   = rot ^ sum;
    end

endmodule

// File: rtl/crypto_feistel_slave.sv
// -----------------------------------------------------------------------------
// crypto_feistel_slave
//   Memory-mapped iterative Feistel cipher (two 19-bit halves, one round per
//   cycle). Software loads KEY0/KEY1/DIN_L/DIN_R, writes START (+MODE) to
//   CTRL, polls STAT for DONE and reads DOUT_L/DOUT_R.
//   Ports:
//     clk    in   1   rising-edge clock
//     rst    in   1   synchronous active-high reset
//     valid  in   1   bus select
//     write  in   1   1 = write, 0 = read
//     addr   in   19  word address, only addr[2:0] decoded
//     wdata  in   19  write data
//     rdata  out  19  combinational read data (0 when not reading)
// -----------------------------------------------------------------------------
module crypto_feistel_slave
    import crypto_pkg::*;
#(
    parameter int           ROUNDS   = 8,
    parameter logic [W-1:0] ID_VALUE = ID_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic         write,
    input  logic [W-1:0] addr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);

    // Software-visible registers.
    logic [W-1:0] key0_q,   key0_d;
    logic [W-1:0] key1_q,   key1_d;
    logic [W-1:0] din_l_q,  din_l_d;
    logic [W-1:0] din_r_q,  din_r_d;
    logic [W-1:0] dout_l_q, dout_l_d;
    logic [W-1:0] dout_r_q, dout_r_d;
    logic         done_q,   done_d;
    logic         mode_q,   mode_d;

    // Working copy of the operation, snapshotted at START so later bus
    // writes to KEY/DIN cannot disturb a running operation.
    logic [W-1:0] wl_q,  wl_d;
    logic [W-1:0] wr_q,  wr_d;
    logic [W-1:0] wk0_q, wk0_d;
    logic [W-1:0] wk1_q, wk1_d;
    logic [2:0]   cnt_q, cnt_d;
    state_e       state_q, state_d;

    logic         wr_en;
    logic         rd_en;
    logic [2:0]   reg_sel;
    logic         start_req;
    logic         clr_req;
    logic [W-1:0] f_x;
    logic [W-1:0] f_k;
    logic [W-1:0] f_out;
    logic [W-1:0] round_l;
    logic [W-1:0] round_r;
    logic         last_round;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^addr[W-1:3];

    assign reg_sel   = addr[2:0];
    assign wr_en     = valid & write;
    assign rd_en     = valid & ~write;
    assign start_req = wr_en && (reg_sel == A_CTRL) && wdata[CTRL_START];
    assign clr_req   = wr_en && (reg_sel == A_CTRL) && wdata[CTRL_DONE_CLR];

    // Encrypt feeds F with R, decrypt with L; the key follows counter parity.
    assign f_x = mode_q ? wl_q : wr_q;
    assign f_k = round_key(wk0_q, wk1_q, cnt_q);

    feistel_f u_feistel_f (
        .x (f_x),
        .k (f_k),
        .f (f_out)
    );

    assign round_l    = mode_q ? (wr_q ^ f_out) : wr_q;
    assign round_r    = mode_q ? wl_q           : (wl_q ^ f_out);
    assign last_round = mode_q ? (cnt_q == 3'd0) : (cnt_q == LAST_ROUND);

    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        key0_d   = key0_q;
        key1_d   = key1_q;
        din_l_d  = din_l_q;
        din_r_d  = din_r_q;
        dout_l_d = dout_l_q;
        dout_r_d = dout_r_q;
        done_d   = done_q;
        mode_d   = mode_q;
        wl_d     = wl_q;
        wr_d     = wr_q;
        wk0_d    = wk0_q;
        wk1_d    = wk1_q;
        cnt_d    = cnt_q;
        state_d  = state_q;

        // Register-file writes are accepted in any state.
        if (wr_en) begin
            case (reg_sel)
                A_KEY0:  key0_d  = wdata;
                A_KEY1:  key1_d  = wdata;
                A_DIN_L: din_l_d = wdata;
                A_DIN_R: din_r_d = wdata;
                default: ;
            endcase
        end

        if (clr_req) begin
            done_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    wl_d    = din_l_q;
                    wr_d    = din_r_q;
                    wk0_d   = key0_q;
                    wk1_d   = key1_q;
                    mode_d  = wdata[CTRL_MODE];
                    cnt_d   = wdata[CTRL_MODE] ? LAST_ROUND : 3'd0;
                    done_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wl_d = round_l;
                wr_d = round_r;
                if (last_round) begin
                    // Completion overrides a DONE_CLR arriving on the same edge.
                    dout_l_d = round_l;
                    dout_r_d = round_r;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = mode_q ? (cnt_q - 3'd1) : (cnt_q + 3'd1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            key0_q   <= '0;
            key1_q   <= '0;
            din_l_q  <= '0;
            din_r_q  <= '0;
            dout_l_q <= '0;
            dout_r_q <= '0;
            done_q   <= 1'b0;
            mode_q   <= 1'b0;
            wl_q     <= '0;
            wr_q     <= '0;
            wk0_q    <= '0;
            wk1_q    <= '0;
            cnt_q    <= 3'd0;
            state_q  <= S_IDLE;
        end else begin
            key0_q   <= key0_d;
            key1_q   <= key1_d;
            din_l_q  <= din_l_d;
            din_r_q  <= din_r_d;
            dout_l_q <= dout_l_d;
            dout_r_q <= dout_r_d;
            done_q   <= done_d;
            mode_q   <= mode_d;
            wl_q     <= wl_d;
            wr_q     <= wr_d;
            wk0_q    <= wk0_d;
            wk1_q    <= wk1_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    // Read mux: zero unless a read is presented this cycle.
    always_comb begin
        rdata = '0;
        if (rd_en) begin
            case (reg_sel)
                A_CTRL: begin
                    rdata[STAT_BUSY] = (state_q == S_RUN);
                    rdata[STAT_DONE] = done_q;
                    rdata[STAT_MODE] = mode_q;
                end
                A_KEY0:   rdata = key0_q;
                A_KEY1:   rdata = key1_q;
                A_DIN_L:  rdata = din_l_q;
                A_DIN_R:  rdata = din_r_q;
                A_DOUT_L: rdata = dout_l_q;
                A_DOUT_R: rdata = dout_r_q;
                A_ID:     rdata = ID_VALUE;
                default:  rdata = '0;
            endcase
        end
    end

endmodule
